// File: rtl/updown_counter_sequencer.sv
// Command sequencer for an 8-bit up/down counter: expands LOAD/UP/DOWN/HOLD commands
// into cycle-accurate en/m/load/data_in drive with zero-bubble chaining.
module updown_counter_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  input  logic              abort,
  output logic              en,
  output logic              m,
  output logic              load,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0]        OP_LOAD  = 2'b00;
  localparam logic [1:0]        OP_UP    = 2'b01;
  localparam logic [1:0]        OP_DOWN  = 2'b10;
  localparam logic [1:0]        OP_HOLD  = 2'b11;
  localparam logic [DATA_W-1:0] REM_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] REM_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [1:0]          op_r, op_s;
  logic [DATA_W-1:0]   rem_r, rem_s;
  logic                en_r, en_s;
  logic                m_r, m_s;
  logic                load_r, load_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic                done_r, done_s;
  logic                accept_s;

  // Ready in IDLE or on the last run cycle so the next command chains without a gap.
  assign cmd_ready = rst_n && !abort && ((state_r == IDLE) || (rem_r == REM_ONE));
  assign accept_s  = cmd_valid && cmd_ready;

  assign en      = en_r;
  assign m       = m_r;
  assign load    = load_r;
  assign data_in = data_r;
  assign busy    = (state_r == RUN);
  assign done    = done_r;

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    rem_s   = rem_r;
    en_s    = en_r;
    m_s     = m_r;
    load_s  = load_r;
    data_s  = data_r;
    done_s  = 1'b0;
    if (abort) begin
      state_s = IDLE;
      rem_s   = REM_ZERO;
      en_s    = 1'b0;
      m_s     = 1'b0;
      load_s  = 1'b0;
    end else if (accept_s) begin
      state_s = RUN;
      en_s    = 1'b0;
      m_s     = 1'b0;
      load_s  = 1'b0;
      case (cmd_op)
        OP_LOAD: begin
          op_s   = OP_LOAD;
          rem_s  = REM_ONE;
          load_s = 1'b1;
          data_s = cmd_arg;
        end
        OP_UP, OP_DOWN: begin
          // A zero step count degenerates to a single idle drive cycle.
          if (cmd_arg == REM_ZERO) begin
            op_s  = OP_HOLD;
            rem_s = REM_ONE;
          end else begin
            op_s  = cmd_op;
            rem_s = cmd_arg;
            en_s  = 1'b1;
            m_s   = (cmd_op == OP_DOWN);
          end
        end
        default: begin
          op_s  = OP_HOLD;
          rem_s = (cmd_arg == REM_ZERO) ? REM_ONE : cmd_arg;
        end
      endcase
      done_s = (rem_s == REM_ONE);
    end else if (state_r == RUN) begin
      if (rem_r == REM_ONE) begin
        state_s = IDLE;
        rem_s   = REM_ZERO;
        en_s    = 1'b0;
        m_s     = 1'b0;
        load_s  = 1'b0;
      end else begin
        rem_s  = rem_r - REM_ONE;
        en_s   = (op_r == OP_UP) || (op_r == OP_DOWN);
        m_s    = (op_r == OP_DOWN);
        load_s = 1'b0;
        done_s = (rem_s == REM_ONE);
      end
    end else begin
      en_s   = 1'b0;
      m_s    = 1'b0;
      load_s = 1'b0;
    end
  end

  // State and registered counter-control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_r    <= OP_LOAD;
      rem_r   <= REM_ZERO;
      en_r    <= 1'b0;
      m_r     <= 1'b0;
      load_r  <= 1'b0;
      data_r  <= REM_ZERO;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      rem_r   <= rem_s;
      en_r    <= en_s;
      m_r     <= m_s;
      load_r  <= load_s;
      data_r  <= data_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Directed bench: drives command sequences into the sequencer and checks its outputs
// and the value of a downstream counter model against hand-computed expectations.
module tb_updown_counter_sequencer;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'd0;
  logic       abort = 1'b0;
  logic       en, m, load, busy, done;
  logic [7:0] data_in;
  logic [7:0] cnt;
  int         errors = 0;
  int         checks = 0;

  updown_counter_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .en(en), .m(m),
    .load(load), .data_in(data_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream counter: load beats enable, wraps modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 8'd0;
    else if (load) cnt <= data_in;
    else if (en) cnt <= m ? cnt - 8'd1 : cnt + 8'd1;
    else cnt <= cnt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] op, input logic [7:0] arg);
    cmd_op = op;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_en", en, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", data_in, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_ready", cmd_ready, 1);

    // LOAD 5 then UP 3 back to back
    put(OP_LOAD, 8'd5);
    chk("t1_ready_load", cmd_ready, 1);
    tick();
    chk("t1_load", load, 1);
    chk("t1_data", data_in, 5);
    chk("t1_done_load", done, 1);
    chk("t1_busy", busy, 1);
    put(OP_UP, 8'd3);
    chk("t1_ready_chain", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t1_cnt5", cnt, 5);
    chk("t1_en", en, 1);
    chk("t1_m", m, 0);
    chk("t1_load_off", load, 0);
    chk("t1_done0", done, 0);
    tick();
    chk("t1_cnt6", cnt, 6);
    chk("t1_done1", done, 0);
    tick();
    chk("t1_cnt7", cnt, 7);
    chk("t1_done_up", done, 1);
    tick();
    chk("t1_cnt8", cnt, 8);
    chk("t1_en_off", en, 0);
    chk("t1_idle", busy, 0);
    chk("t1_done_off", done, 0);

    // LOAD 2, DOWN 4 with wrap
    put(OP_LOAD, 8'd2);
    tick();
    put(OP_DOWN, 8'd4);
    tick();
    cmd_valid = 1'b0;
    chk("t2_cnt2", cnt, 2);
    chk("t2_m1", m, 1);
    tick();
    chk("t2_cnt1", cnt, 1);
    chk("t2_m2", m, 1);
    tick();
    chk("t2_cnt0", cnt, 0);
    chk("t2_m3", m, 1);
    tick();
    chk("t2_cnt255", cnt, 255);
    chk("t2_m4", m, 1);
    chk("t2_done", done, 1);
    tick();
    chk("t2_cnt254", cnt, 254);
    chk("t2_m_off", m, 0);

    // LOAD 9, HOLD 3, UP 0
    put(OP_LOAD, 8'd9);
    tick();
    put(OP_HOLD, 8'd3);
    tick();
    cmd_valid = 1'b0;
    chk("t3_cnt_a", cnt, 9);
    chk("t3_en_a", en, 0);
    chk("t3_done_a", done, 0);
    tick();
    chk("t3_en_b", en, 0);
    chk("t3_done_b", done, 0);
    tick();
    chk("t3_done_c", done, 1);
    put(OP_UP, 8'd0);
    chk("t3_ready_up0", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t3_en_d", en, 0);
    chk("t3_done_d", done, 1);
    chk("t3_busy_d", busy, 1);
    tick();
    chk("t3_cnt_end", cnt, 9);
    chk("t3_idle", busy, 0);
    chk("t3_done_end", done, 0);

    // UP 10 aborted on the 4th run cycle
    put(OP_UP, 8'd10);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_cnt12", cnt, 12);
    abort = 1'b1;
    put(OP_UP, 8'd1);
    chk("t4_ready_abort", cmd_ready, 0);
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("t4_cnt13", cnt, 13);
    chk("t4_en_off", en, 0);
    chk("t4_busy_off", busy, 0);
    chk("t4_no_done", done, 0);
    tick();
    chk("t4_cnt_hold", cnt, 13);

    // cmd_valid held through UP 6: accepted only on the last cycle, no gap in en
    put(OP_UP, 8'd6);
    tick();
    put(OP_UP, 8'd2);
    for (int i = 1; i <= 6; i++) begin
      chk("t5_ready", cmd_ready, (i == 6) ? 1 : 0);
      chk("t5_en", en, 1);
      tick();
      #1;
    end
    cmd_valid = 1'b0;
    chk("t5_cnt19", cnt, 19);
    chk("t5_en_chain", en, 1);
    tick();
    chk("t5_done", done, 1);
    tick();
    chk("t5_cnt21", cnt, 21);
    chk("t5_idle", busy, 0);

    // LOAD 0xA5, reset mid UP 8, then LOAD 7
    put(OP_LOAD, 8'hA5);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6_cnt_a5", cnt, 165);
    put(OP_UP, 8'd8);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("t6_data_kept", data_in, 165);
    chk("t6_cnt_a7", cnt, 167);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", data_in, 0);
    chk("t6_rst_ready", cmd_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", cmd_ready, 1);
    chk("t6_rel_done", done, 0);
    put(OP_LOAD, 8'd7);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6_cnt7", cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
